// File: rtl/pll_supervisor_pkg.sv
// -----------------------------------------------------------------------------
// pll_supervisor_pkg
//
// Purpose : Shared definitions for the PLL supervisor: FSM state encoding,
//           default parameter values and the shared down-counter width helper.
//
// Contents:
//   state_t        - FSM state encoding (PLL_RST..RUN, values 0..4)
//   DEF_*          - default parameter values used by pll_supervisor
//   cnt_width()    - width of the single down-counter shared by all states
// -----------------------------------------------------------------------------
package pll_supervisor_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    localparam int DEF_NUM_CH       = 3;
    localparam int DEF_RST_HOLD     = 8;
    localparam int DEF_LOCK_TIMEOUT = 4096;
    localparam int DEF_LOCK_STABLE  = 256;
    localparam int DEF_RELEASE_GAP  = 16;

    // clog2 of the largest interval the shared counter has to time. Every
    // reload value is (interval - 1), so this width always fits the reloads.
    function automatic int cnt_width(input int rst_hold,
                                     input int lock_timeout,
                                     input int lock_stable,
                                     input int num_ch,
                                     input int release_gap);
        int m;
        int w;
        m = rst_hold;
        if (lock_timeout > m) m = lock_timeout;
        if (lock_stable > m) m = lock_stable;
        if (((num_ch - 1) * release_gap + 1) > m) m = (num_ch - 1) * release_gap + 1;
        w = $clog2(m);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/pll_supervisor_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//
// Purpose : Plain two-flop synchroniser for slow, level-type asynchronous
//           signals. Generic so other blocks can reuse it.
//
// Parameters:
//   WIDTH  - number of independent bits synchronised
//
// Ports:
//   i_clk  in  1      destination clock
//   i_rst  in  1      asynchronous active-high reset (both stages clear to 0)
//   i_d    in  WIDTH  asynchronous input
//   o_q    out WIDTH  synchronised output (2 destination edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_supervisor.sv
// -----------------------------------------------------------------------------
// pll_supervisor
//
// Purpose : Runs on the free-running reference clock next to the vendor PLL
//           wrapper. Holds the PLL in reset, qualifies the asynchronous lock
//           signal (2-flop synchroniser + stability window), releases the
//           downstream domain resets one after another, detects loss of lock,
//           retries on lock timeout, honours a software relock request and
//           counts PLL resets.
//
// Build option:
//   PLL_SUPERVISOR_TIMEOUT_EN - when defined, WAIT_LOCK gives up after
//                               LOCK_TIMEOUT cycles and re-resets the PLL.
//                               When undefined, WAIT_LOCK waits forever and
//                               LOCK_TIMEOUT does not affect the hardware.
//
// Parameters:
//   NUM_CH        downstream reset channels (1..5)
//   RST_HOLD      cycles pll_reset is held per PLL reset (>=2)
//   LOCK_TIMEOUT  WAIT_LOCK cycles before retry
//   LOCK_STABLE   consecutive synchronised-lock samples before release (>=1)
//   RELEASE_GAP   cycles between successive channel releases (>=1)
//
// Ports:
//   refclk        in  1       reference clock, the only clock
//   reset         in  1       asynchronous active-high reset
//   extlock       in  1       PLL lock, asynchronous to refclk
//   force_relock  in  1       single-cycle request to re-reset the PLL
//   pll_reset     out 1       active-high PLL reset
//   ch_rst        out NUM_CH  active-high domain resets, bit i released i-th
//   locked        out 1       high only in RUN
//   lock_lost     out 1       one-cycle pulse when lock drops in RUN
//   relock_count  out 8       saturating count of PLL resets since power-on
//   state         out 3       current FSM state (pll_supervisor_pkg::state_t)
//
// Handshake: there is none; force_relock is a plain level sampled every
// cycle and ignored while the PLL is already being held in reset.
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module pll_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int RST_HOLD     = DEF_RST_HOLD,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int RELEASE_GAP  = DEF_RELEASE_GAP
) (
    input  logic              refclk,
    input  logic              reset,
    input  logic              extlock,
    input  logic              force_relock,
    output logic              pll_reset,
    output logic [NUM_CH-1:0] ch_rst,
    output logic              locked,
    output logic              lock_lost,
    output logic [7:0]        relock_count,
    output logic [2:0]        state
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------
    if (NUM_CH < 1 || NUM_CH > 5) begin : g_bad_num_ch
        $error("pll_supervisor: NUM_CH must be in 1..5");
    end
    if (RST_HOLD < 2) begin : g_bad_rst_hold
        $error("pll_supervisor: RST_HOLD must be >= 2");
    end
    if (LOCK_TIMEOUT < 1) begin : g_bad_lock_timeout
        $error("pll_supervisor: LOCK_TIMEOUT must be >= 1");
    end
    if (LOCK_STABLE < 1) begin : g_bad_lock_stable
        $error("pll_supervisor: LOCK_STABLE must be >= 1");
    end
    if (RELEASE_GAP < 1) begin : g_bad_release_gap
        $error("pll_supervisor: RELEASE_GAP must be >= 1");
    end

    // ------------------------------------------------------------------
    // Shared down-counter sizing and reload values
    // ------------------------------------------------------------------
`ifdef PLL_SUPERVISOR_TIMEOUT_EN
    localparam int EFF_TIMEOUT = LOCK_TIMEOUT;
`else
    localparam int EFF_TIMEOUT = 1;
`endif

    localparam int CNT_W = cnt_width(RST_HOLD, EFF_TIMEOUT, LOCK_STABLE,
                                     NUM_CH, RELEASE_GAP);

    // A state that must last N cycles is loaded with N-1 on entry and is
    // left on the edge where the counter is already 0.
    localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_STABLE  = CNT_W'(LOCK_STABLE - 1);
    // RELEASE spans (NUM_CH-1)*RELEASE_GAP+1 cycles: channel i is released
    // on the edge where the counter reads (NUM_CH-1-i)*RELEASE_GAP, so the
    // last channel drops on the same edge that enters RUN.
    localparam logic [CNT_W-1:0] LD_RELEASE = CNT_W'((NUM_CH - 1) * RELEASE_GAP);
`ifdef PLL_SUPERVISOR_TIMEOUT_EN
    localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(LOCK_TIMEOUT - 1);
`endif

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_cnt_zero;
    logic                r_boot;
    logic                w_lock_s;
    logic [NUM_CH-1:0]   r_ch_rst;
    logic [NUM_CH-1:0]   w_ch_rst_next;
    logic                r_pll_reset;
    logic                r_locked;
    logic                r_lock_lost;
    logic                w_lock_lost_next;
    logic                w_relock_inc;
    logic [7:0]          r_relock_count;

    // ------------------------------------------------------------------
    // Lock synchroniser: the only path from extlock into the logic
    // ------------------------------------------------------------------
    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .i_clk (refclk),
        .i_rst (reset),
        .i_d   (extlock),
        .o_q   (w_lock_s)
    );

    assign w_cnt_zero = (r_cnt == '0);

    // ------------------------------------------------------------------
    // FSM next-state
    // ------------------------------------------------------------------
    always_comb begin
        w_next           = r_state;
        w_lock_lost_next = 1'b0;

        case (r_state)
            PLL_RST: begin
                if (w_cnt_zero) w_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_next = STABLE;
                end
`ifdef PLL_SUPERVISOR_TIMEOUT_EN
                else if (w_cnt_zero) begin
                    w_next = PLL_RST;
                end
`endif
            end
            STABLE: begin
                if (!w_lock_s)       w_next = WAIT_LOCK;
                else if (w_cnt_zero) w_next = RELEASE;
            end
            RELEASE: begin
                if (!w_lock_s)       w_next = PLL_RST;
                else if (w_cnt_zero) w_next = RUN;
            end
            RUN: begin
                if (!w_lock_s) begin
                    w_next           = PLL_RST;
                    w_lock_lost_next = 1'b1;
                end
            end
            default: begin
                w_next = PLL_RST;
            end
        endcase

        // A relock request overrides everything except an ongoing PLL reset,
        // which it neither restarts nor extends. lock_lost keeps its pulse.
        if (force_relock && (r_state != PLL_RST)) begin
            w_next = PLL_RST;
        end
    end

    // ------------------------------------------------------------------
    // Shared counter: reload on every state change, otherwise count down
    // and stick at 0. The very first cycle after reset is an extra PLL_RST
    // hold cycle, so the counter is frozen for that one edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_next != r_state) begin
            case (w_next)
                PLL_RST:   w_cnt_next = LD_HOLD;
`ifdef PLL_SUPERVISOR_TIMEOUT_EN
                WAIT_LOCK: w_cnt_next = LD_TIMEOUT;
`else
                WAIT_LOCK: w_cnt_next = '0;
`endif
                STABLE:    w_cnt_next = LD_STABLE;
                RELEASE:   w_cnt_next = LD_RELEASE;
                default:   w_cnt_next = '0;
            endcase
        end else if (!r_boot && !w_cnt_zero) begin
            w_cnt_next = r_cnt - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Channel resets: all set on PLL_RST entry, cleared one by one in
    // RELEASE, never reasserted individually.
    // ------------------------------------------------------------------
    always_comb begin
        w_ch_rst_next = r_ch_rst;
        if (w_next == PLL_RST) begin
            w_ch_rst_next = '1;
        end else if (r_state == RELEASE) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_cnt == CNT_W'((NUM_CH - 1 - i) * RELEASE_GAP)) begin
                    w_ch_rst_next[i] = 1'b0;
                end
            end
        end
    end

    // Every entry into PLL_RST from another state counts once, whatever
    // combination of causes triggered it.
    assign w_relock_inc = (w_next == PLL_RST) && (r_state != PLL_RST)
                          && (r_relock_count != 8'hFF);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            r_state        <= PLL_RST;
            r_cnt          <= LD_HOLD;
            r_boot         <= 1'b1;
            r_ch_rst       <= '1;
            r_pll_reset    <= 1'b1;
            r_locked       <= 1'b0;
            r_lock_lost    <= 1'b0;
            r_relock_count <= 8'd0;
        end else begin
            r_state        <= w_next;
            r_cnt          <= w_cnt_next;
            r_boot         <= 1'b0;
            r_ch_rst       <= w_ch_rst_next;
            r_pll_reset    <= (w_next == PLL_RST);
            r_locked       <= (w_next == RUN);
            r_lock_lost    <= w_lock_lost_next;
            if (w_relock_inc) begin
                r_relock_count <= r_relock_count + 8'd1;
            end
        end
    end

    assign pll_reset    = r_pll_reset;
    assign ch_rst       = r_ch_rst;
    assign locked       = r_locked;
    assign lock_lost    = r_lock_lost;
    assign relock_count = r_relock_count;
    assign state        = r_state;

endmodule

// File: tb/tb_pll_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_supervisor
//
// Directed sequence against pll_supervisor with NUM_CH=3, RST_HOLD=8,
// LOCK_STABLE=16, RELEASE_GAP=4, LOCK_TIMEOUT=100. Expected output vectors
// are queued with the cycle at which they must appear and compared at that
// cycle, 1 time unit after the rising refclk edge.
//
// Cycle numbering: the first refclk rising edge after reset is released is
// cycle 0; "cycle n" below is the state just after edge n.
// Observed vector layout: {state[2:0], pll_reset, ch_rst[2:0], locked,
// lock_lost, relock_count[7:0]}.
// -----------------------------------------------------------------------------
module tb_pll_supervisor;

    localparam int NC = 3;
    localparam int RH = 8;
    localparam int LS = 16;
    localparam int RG = 4;
    localparam int LT = 100;

    logic          refclk;
    logic          reset;
    logic          extlock;
    logic          force_relock;
    logic          pll_reset;
    logic [NC-1:0] ch_rst;
    logic          locked;
    logic          lock_lost;
    logic [7:0]    relock_count;
    logic [2:0]    state;

    pll_supervisor #(
        .NUM_CH       (NC),
        .RST_HOLD     (RH),
        .LOCK_TIMEOUT (LT),
        .LOCK_STABLE  (LS),
        .RELEASE_GAP  (RG)
    ) dut (
        .refclk       (refclk),
        .reset        (reset),
        .extlock      (extlock),
        .force_relock (force_relock),
        .pll_reset    (pll_reset),
        .ch_rst       (ch_rst),
        .locked       (locked),
        .lock_lost    (lock_lost),
        .relock_count (relock_count),
        .state        (state)
    );

    // ---------------- clock ----------------
    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    // ---------------- scoreboard ----------------
    logic [16:0] exp_q[$];
    int          at_q[$];
    string       tag_q[$];
    int          total;
    int          bad;
    int          cyc;
    int          rc_exp;

    function automatic logic [16:0] mk(input logic [2:0] st, input logic pr,
                                       input logic [2:0] ch, input logic lk,
                                       input logic ll, input logic [7:0] rc);
        return {st, pr, ch, lk, ll, rc};
    endfunction

    function automatic logic [16:0] obs();
        return {state, pll_reset, ch_rst, locked, lock_lost, relock_count};
    endfunction

    task automatic check_now(input string tag, input logic [16:0] exp);
        logic [16:0] got;
        got = obs();
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s @cyc %0d: got st=%0d pr=%b ch=%b lk=%b ll=%b rc=%0d, expected st=%0d pr=%b ch=%b lk=%b ll=%b rc=%0d",
                   tag, cyc, got[16:14], got[13], got[12:10], got[9], got[8], got[7:0],
                   exp[16:14], exp[13], exp[12:10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic expect_at(input int at, input string tag, input logic [16:0] v);
        at_q.push_back(at);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic drain();
        int          at;
        string       t;
        logic [16:0] v;
        while (at_q.size() > 0 && at_q[0] <= cyc) begin
            at = at_q.pop_front();
            t  = tag_q.pop_front();
            v  = exp_q.pop_front();
            check_now(t, v);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
        cyc++;
        drain();
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        int rc_next;

        total        = 0;
        bad          = 0;
        cyc          = -1;
        rc_exp       = 0;
        reset        = 1'b1;
        extlock      = 1'b0;
        force_relock = 1'b0;

        repeat (2) @(posedge refclk);
        #1;
        check_now("reset_values", mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd0));
        reset = 1'b0;
        cyc   = -1;

        // Baseline power-up and staggered release
        expect_at(0,  "cyc0_pll_rst",    mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd0));
        expect_at(7,  "pll_reset_hold",  mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd0));
        expect_at(8,  "pll_reset_fall",  mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 8'd0));
        expect_at(20, "wait_no_lock",    mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 8'd0));
        run_to(20);
        extlock = 1'b1;
        expect_at(22, "sync_latency",    mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 8'd0));
        expect_at(23, "stable_entry",    mk(3'd2, 1'b0, 3'b111, 1'b0, 1'b0, 8'd0));
        expect_at(38, "stable_last",     mk(3'd2, 1'b0, 3'b111, 1'b0, 1'b0, 8'd0));
        expect_at(39, "release_entry",   mk(3'd3, 1'b0, 3'b111, 1'b0, 1'b0, 8'd0));
        expect_at(40, "ch0_release",     mk(3'd3, 1'b0, 3'b110, 1'b0, 1'b0, 8'd0));
        expect_at(43, "ch1_not_yet",     mk(3'd3, 1'b0, 3'b110, 1'b0, 1'b0, 8'd0));
        expect_at(44, "ch1_release",     mk(3'd3, 1'b0, 3'b100, 1'b0, 1'b0, 8'd0));
        expect_at(47, "ch2_not_yet",     mk(3'd3, 1'b0, 3'b100, 1'b0, 1'b0, 8'd0));
        expect_at(48, "ch2_and_locked",  mk(3'd4, 1'b0, 3'b000, 1'b1, 1'b0, 8'd0));
        expect_at(52, "run_hold",        mk(3'd4, 1'b0, 3'b000, 1'b1, 1'b0, 8'd0));
        run_to(52);

        // Lock loss in RUN
        extlock = 1'b0;
        expect_at(54, "run_before_loss", mk(3'd4, 1'b0, 3'b000, 1'b1, 1'b0, 8'd0));
        expect_at(55, "lock_lost_pulse", mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b1, 8'd1));
        expect_at(56, "lock_lost_once",  mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd1));
        expect_at(62, "relock_hold",     mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd1));
        expect_at(63, "relock_release",  mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 8'd1));
        run_to(63);

        // Lock glitch during STABLE
        extlock = 1'b1;
        expect_at(65, "glitch_wait",     mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 8'd1));
        expect_at(66, "glitch_stable",   mk(3'd2, 1'b0, 3'b111, 1'b0, 1'b0, 8'd1));
        expect_at(76, "stable_10",       mk(3'd2, 1'b0, 3'b111, 1'b0, 1'b0, 8'd1));
        run_to(76);
        extlock = 1'b0;
        expect_at(78, "stable_pre_drop", mk(3'd2, 1'b0, 3'b111, 1'b0, 1'b0, 8'd1));
        expect_at(79, "back_to_wait",    mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 8'd1));
        run_to(79);
        extlock = 1'b1;
        expect_at(81, "wait_again",      mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 8'd1));
        expect_at(82, "stable_restart",  mk(3'd2, 1'b0, 3'b111, 1'b0, 1'b0, 8'd1));
        expect_at(97, "window_restart",  mk(3'd2, 1'b0, 3'b111, 1'b0, 1'b0, 8'd1));
        expect_at(98, "release_again",   mk(3'd3, 1'b0, 3'b111, 1'b0, 1'b0, 8'd1));
        expect_at(99, "ch0_again",       mk(3'd3, 1'b0, 3'b110, 1'b0, 1'b0, 8'd1));
        expect_at(100, "before_force",   mk(3'd3, 1'b0, 3'b110, 1'b0, 1'b0, 8'd1));
        run_to(100);

        // force_relock during RELEASE, then an ignored one during PLL_RST
        force_relock = 1'b1;
        expect_at(101, "force_release",  mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd2));
        run_to(101);
        force_relock = 1'b0;
        expect_at(103, "force_hold",     mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd2));
        run_to(103);
        force_relock = 1'b1;
        expect_at(104, "force_ignored",  mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd2));
        run_to(104);
        force_relock = 1'b0;
        extlock      = 1'b0;
        expect_at(108, "hold_not_ext",   mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd2));
        expect_at(109, "hold_end",       mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 8'd2));
        run_to(109);
        rc_exp = 2;

        // WAIT_LOCK with lock held low
`ifdef PLL_SUPERVISOR_TIMEOUT_EN
        expect_at(208, "to1_wait",       mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 8'd2));
        expect_at(209, "to1_retry",      mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd3));
        expect_at(216, "to1_hold",       mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd3));
        expect_at(217, "to1_wait_again", mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 8'd3));
        expect_at(316, "to2_wait",       mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 8'd3));
        expect_at(317, "to2_retry",      mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd4));
        expect_at(325, "to2_wait_again", mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 8'd4));
        expect_at(424, "to3_wait",       mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 8'd4));
        expect_at(425, "to3_retry",      mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd5));
        expect_at(433, "to3_wait_again", mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 8'd5));
        run_to(433);
        rc_exp = 5;
`else
        for (int k = 1; k <= 10; k++) begin
            expect_at(109 + 100 * k, "no_timeout", mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 8'd2));
        end
        run_to(1109);
`endif

        // 300 forced relocks from WAIT_LOCK, saturating the counter
        for (int i = 0; i < 300; i++) begin
            base    = cyc;
            rc_next = (rc_exp == 255) ? 255 : rc_exp + 1;
            force_relock = 1'b1;
            expect_at(base + 1, "sat_force", mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, rc_next[7:0]));
            tick();
            force_relock = 1'b0;
            expect_at(base + 9, "sat_wait",  mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, rc_next[7:0]));
            run_to(base + 9);
            rc_exp = rc_next;
        end
        expect_at(cyc + 1, "sat_255", mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 8'd255));
        tick();

        // Async reset in the middle of RELEASE
        base    = cyc;
        extlock = 1'b1;
        expect_at(base + 3,  "pre_rst_stable",  mk(3'd2, 1'b0, 3'b111, 1'b0, 1'b0, 8'd255));
        expect_at(base + 19, "pre_rst_release", mk(3'd3, 1'b0, 3'b111, 1'b0, 1'b0, 8'd255));
        expect_at(base + 21, "pre_rst_ch0",     mk(3'd3, 1'b0, 3'b110, 1'b0, 1'b0, 8'd255));
        run_to(base + 21);
        #2;
        reset = 1'b1;
        #1;
        check_now("async_reset", mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd0));
        @(posedge refclk);
        #1;
        check_now("reset_held", mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd0));
        reset = 1'b0;
        cyc   = -1;
        expect_at(0, "post_rst_cyc0",   mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd0));
        expect_at(8, "post_rst_wait",   mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 8'd0));
        expect_at(9, "post_rst_stable", mk(3'd2, 1'b0, 3'b111, 1'b0, 1'b0, 8'd0));
        run_to(10);

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
